int_to_float_converter: RTL and testbench
=========================================

# int_to_float_converter

Sequential converter from 8-bit sign-magnitude integers to the 13-bit float format. Bit 12 is the sign, bits 11:8 the exponent, and bits 7:0 the significand; the value is significand·2^(exponent−8), and the significand MSB is set for every non-zero value. The block is the upstream producer for `float_to_int_converter`. It normalizes by shifting one bit per cycle under valid/ready handshakes on both sides, so every non-zero output round-trips exactly through the downstream stage.

## Interface
- No parameters; all widths are fixed by the float format.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_ni`  in  1  asynchronous, active-low reset.
- `int_i`  in  8  sign-magnitude integer: bit 7 is the sign, bits 6:0 the magnitude (0..127).
- `in_valid_i`  in  1  `int_i` is valid.
- `in_ready_o`  out  1  block can accept an input.
- `float_o`  out  13  result: {sign, exponent[3:0], significand[7:0]}.
- `out_valid_o`  out  1  `float_o` is valid.
- `out_ready_i`  in  1  consumer accepts `float_o`.

## Operation
- FSM states: IDLE, NORM, DONE.
- `in_ready_o` = (state == IDLE).
- `out_valid_o` = (state == DONE).
- Internal registers:
  - `sign_q` (1 bit)
  - `exp_q` (4 bits)
  - `sig_q` (8 bits)
- `float_o` = {`sign_q`, `exp_q`, `sig_q`}.
- IDLE, accept (`in_valid_i` && `in_ready_o`):
  - magnitude m = `int_i[6:0]`.
  - If m == 0: load sign 0, exp 0, sig 0, and go to DONE. A negative zero is canonicalized to +0.
  - Otherwise: load sign = `int_i[7]`, exp = 8, sig = {1'b0, m}, and go to NORM.
- NORM: each cycle, sig ← sig << 1 and exp ← exp − 1.
  - Go to DONE on the edge where the shifted sig has bit 7 set.
  - The shift count is lz(m) = 8 − bitlength(m), so it ranges from 1 (m ≥ 64) to 7 (m = 1). The final exp is bitlength(m), in the range 1..7.
  - Exp therefore never underflows and never exceeds 8, and the loop needs no extra exit condition.
- DONE: `float_o` is held stable.
  - If `out_ready_i` = 1, go to IDLE on that edge.
  - Otherwise stay in DONE indefinitely; `out_ready_i` stalls do not corrupt or change `float_o`.
- No input is accepted while in NORM or DONE.
- `int_i` is sampled only on the accept edge; later changes to `int_i` have no effect.
- Arithmetic: the shift is a logical left shift with a 0 fill, and the exponent is a 4-bit unsigned decrement.

## Timing
- Reset (`rst_ni` = 0, asynchronous, takes effect immediately):
  - state = IDLE
  - `sign_q`/`exp_q`/`sig_q` = 0, so `float_o` = 13'h0000
  - `out_valid_o` = 0
  - `in_ready_o` = 1
- Reset asserted in NORM or DONE abandons the conversion. No output handshake completes for it.
- Latency, counting from the accept edge to the edge after which `out_valid_o` = 1:
  - L = 0 for m = 0 (`out_valid_o` is high the cycle after accept).
  - L = lz(m) otherwise.
- Output handshake completes on the edge where `out_valid_o` && `out_ready_i`. `out_valid_o` drops after that edge, and `in_ready_o` rises in the same cycle.
- Best-case throughput is one conversion per L+2 cycles (accept cycle, L NORM cycles, DONE cycle). With `out_ready_i` held high, IDLE lasts a single cycle when `in_valid_i` is already high.

## Test plan
- Reset, then an m = 0 conversion:
  - After reset release, expect `float_o` = 0, `out_valid_o` = 0, `in_ready_o` = 1.
  - Present `int_i` = 8'h80 (−0) → one cycle later `float_o` = 13'h0000, `out_valid_o` = 1.
- Minimum magnitude: `int_i` = 8'h01 → after 7 NORM cycles `float_o` = {0, 4'd1, 8'h80}. Re-verify L = 7.
- Maximum magnitude, negative: `int_i` = 8'hFF (−127) → after 1 NORM cycle `float_o` = {1, 4'd7, 8'hFE}, L = 1.
- Backpressure:
  - Convert 8'h05 (expected {0, 4'd3, 8'hA0}) with `out_ready_i` held low for 10 cycles.
  - `float_o` stays stable and `in_ready_o` stays 0.
  - Drive `in_valid_i` with 8'h7F during the stall → it is ignored.
  - Release `out_ready_i` → exactly one handshake, then IDLE.
- Reset mid-conversion: accept 8'h01 and assert `rst_ni` low on the 3rd NORM cycle → immediately `out_valid_o` = 0, `float_o` = 0, and no output handshake follows.
- Exhaustive round-trip: all 256 `int_i` values with random `out_ready_i` stalls.
  - Feed `float_o` to a reference `float_to_int_converter`.
  - Its output must equal `int_i` for every input except 8'h80, which returns 8'h00.
  - For every input, exp = bitlength(m), sig[7] = 1 when m ≠ 0, and measured latency = L.

Source files
------------

// File: rtl/int_to_float_converter.sv
// Sign-magnitude int8 to 13-bit float {sign, exp[3:0], sig[7:0]} converter.
// Normalizes one bit per cycle behind valid/ready handshakes on both sides.
module int_to_float_converter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [7:0]  int_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic [12:0] float_o,
  output logic        out_valid_o,
  input  logic        out_ready_i
);

  // state | meaning
  // IDLE  | waiting for an input, in_ready_o high
  // NORM  | shifting sig left until its MSB is set
  // DONE  | result presented, waiting for out_ready_i
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [3:0]  exp_q, exp_d;
  logic [7:0]  sig_q, sig_d;
  logic [6:0]  w_mag;
  logic [7:0]  w_sig_shl;

  assign w_mag     = int_i[6:0];
  assign w_sig_shl = sig_q << 1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      sign_q  <= 1'b0;
      exp_q   <= 4'd0;
      sig_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      sign_q  <= sign_d;
      exp_q   <= exp_d;
      sig_q   <= sig_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sign_d  = sign_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    case (state_q)
      IDLE: begin
        if (in_valid_i) begin
          if (w_mag == 7'd0) begin
            // negative zero is canonicalized to +0
            sign_d  = 1'b0;
            exp_d   = 4'd0;
            sig_d   = 8'd0;
            state_d = DONE;
          end else begin
            sign_d  = int_i[7];
            exp_d   = 4'd8;
            sig_d   = {1'b0, w_mag};
            state_d = NORM;
          end
        end
      end
      NORM: begin
        // m is non-zero here, so the MSB is reached within 7 shifts
        sig_d = w_sig_shl;
        exp_d = exp_q - 4'd1;
        if (w_sig_shl[7]) state_d = DONE;
      end
      DONE: begin
        if (out_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready_o  = (state_q == IDLE);
  assign out_valid_o = (state_q == DONE);
  assign float_o     = {sign_q, exp_q, sig_q};

endmodule

// File: tb/tb_int_to_float_converter.sv
// Directed + exhaustive bench for int_to_float_converter with a scoreboard
// and a behavioural float-to-int reference for the round-trip check.
module tb_int_to_float_converter;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  int_i = 8'h00;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [12:0] float_o;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;

  typedef struct {
    logic [7:0]  in;
    logic [12:0] fl;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int vectors = 0;
  int miscompares = 0;

  int_to_float_converter dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .int_i       (int_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .float_o     (float_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic int bitlen(input logic [6:0] m);
    for (int i = 6; i >= 0; i--) if (m[i]) return i + 1;
    return 0;
  endfunction

  function automatic logic [12:0] model(input logic [7:0] v);
    logic [7:0] s;
    int bl;
    if (v[6:0] == 7'd0) return 13'h0000;
    bl = bitlen(v[6:0]);
    s = {1'b0, v[6:0]};
    s = s << (8 - bl);
    return {v[7], 4'(bl), s};
  endfunction

  // reference downstream stage: value = sig * 2^(exp-8)
  function automatic logic [7:0] f2i(input logic [12:0] f);
    logic [7:0] mag;
    int e;
    if (f[7:0] == 8'd0) return 8'h00;
    e = int'(f[11:8]);
    if (e > 8) return 8'hxx;
    mag = f[7:0] >> (8 - e);
    return {f[12], mag[6:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic timeout(input string tag);
    vectors++;
    miscompares++;
    $error("FAIL %s observed=timeout expected=event", tag);
  endtask

  task automatic convert(input logic [7:0] v, input int stall, input bit poke);
    int n;
    exp_t e;
    exp_t got;
    logic [12:0] held;
    @(negedge clk_i);
    int_i = v;
    in_valid_i = 1'b1;
    n = 0;
    while (!in_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    if (!in_ready_o) begin
      timeout("accept");
      in_valid_i = 1'b0;
      return;
    end
    e.in  = v;
    e.fl  = model(v);
    e.lat = (v[6:0] == 7'd0) ? 0 : 8 - bitlen(v[6:0]);
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    int_i = 8'($urandom);
    n = 0;
    @(negedge clk_i);
    while (!out_valid_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (!out_valid_o) begin
      timeout("out_valid");
      sb.delete();
      return;
    end
    got = sb.pop_front();
    check("latency", n, got.lat);
    check("float", float_o, got.fl);
    check("exp_bitlen", float_o[11:8], bitlen(got.in[6:0]));
    if (got.in[6:0] != 7'd0) check("sig_msb", float_o[7], 1);
    check("roundtrip", f2i(float_o), (got.in == 8'h80) ? 8'h00 : got.in);
    held = float_o;
    repeat (stall) begin
      if (poke) begin
        in_valid_i = 1'b1;
        int_i = 8'h7F;
      end
      @(negedge clk_i);
      check("stall_hold", float_o, held);
      check("stall_in_ready", in_ready_o, 0);
      check("stall_valid", out_valid_o, 1);
    end
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    out_ready_i = 1'b0;
    check("handshake_valid_drop", out_valid_o, 0);
    check("handshake_in_ready", in_ready_o, 1);
    if (poke) begin
      repeat (3) @(negedge clk_i);
      check("post_stall_idle_valid", out_valid_o, 0);
      check("post_stall_idle_ready", in_ready_o, 1);
    end
  endtask

  initial begin
    // reset
    repeat (3) @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("reset_float", float_o, 13'h0000);
    check("reset_valid", out_valid_o, 0);
    check("reset_ready", in_ready_o, 1);

    // directed corners
    convert(8'h80, 0, 1'b0);
    convert(8'h01, 0, 1'b0);
    convert(8'hFF, 0, 1'b0);
    convert(8'h05, 10, 1'b1);

    // reset on the 3rd NORM cycle abandons the conversion
    @(negedge clk_i);
    int_i = 8'h01;
    in_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    in_valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check("midconv_in_norm", in_ready_o, 0);
    rst_ni = 1'b0;
    #1;
    check("midconv_rst_valid", out_valid_o, 0);
    check("midconv_rst_float", float_o, 13'h0000);
    check("midconv_rst_ready", in_ready_o, 1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    out_ready_i = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      check("midconv_no_output", out_valid_o, 0);
    end
    out_ready_i = 1'b0;

    // exhaustive round-trip with random stalls
    for (int i = 0; i < 256; i++) convert(8'(i), int'($urandom_range(0, 3)), 1'b0);

    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
